// File: rtl/inst_sequencer.sv
// Instruction sequencer: fetches a program from instruction memory and issues
// it one instruction at a time to the DSP controller using the start/inst/valid
// handshake. The next instruction is not fetched until the current one completes.
module inst_sequencer #(
  parameter int IMEM_LATENCY = 1,
  parameter int TIMEOUT      = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_start,
  input  logic [9:0]  cmd_base,
  input  logic [9:0]  cmd_count,
  input  logic        cmd_abort,
  output logic        busy,
  output logic        done,
  output logic        err_timeout,
  output logic [9:0]  insts_done,
  output logic        imem_en,
  output logic [9:0]  imem_addr,
  input  logic [31:0] imem_dout,
  output logic        ctrl_start,
  output logic [31:0] ctrl_inst,
  input  logic        ctrl_valid
);

  localparam logic [31:0] HALT = 32'h7FFF_FFFF;
  localparam int          TW   = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT_RD, S_ISSUE, S_WAIT_VALID, S_FINISH
  } state_t;

  state_t          state, state_nxt;
  logic [9:0]      base_q, count_q, idx;
  logic [1:0]      rd_cnt;
  logic [TW-1:0]   tmo_cnt;
  logic            abort_pending;

  // An abort seen this cycle acts immediately, not one cycle late.
  logic abort_any, rd_last, tmo_hit, last_inst;
  assign abort_any = abort_pending | cmd_abort;
  assign rd_last   = (rd_cnt == 2'(IMEM_LATENCY - 1));
  assign tmo_hit   = (tmo_cnt == TW'(TIMEOUT - 1));
  assign last_inst = ((idx + 10'd1) == count_q);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; aborts before the issue strobe skip straight to FINISH
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:       if (cmd_start) state_nxt = (cmd_count == 10'd0) ? S_FINISH : S_FETCH;
      S_FETCH:      state_nxt = abort_any ? S_FINISH : S_WAIT_RD;
      S_WAIT_RD: begin
        if (abort_any)                state_nxt = S_FINISH;
        else if (rd_last)             state_nxt = (imem_dout == HALT) ? S_FINISH : S_ISSUE;
      end
      S_ISSUE:      state_nxt = S_WAIT_VALID;
      S_WAIT_VALID: begin
        // valid wins over a timeout landing in the same cycle
        if (ctrl_valid)               state_nxt = (last_inst || abort_any) ? S_FINISH : S_FETCH;
        else if (tmo_hit)             state_nxt = S_FINISH;
      end
      S_FINISH:     state_nxt = S_IDLE;
      default:      state_nxt = S_IDLE;
    endcase
  end

  // Moore outputs decoded from the current state
  always_comb begin
    busy       = (state != S_IDLE);
    imem_en    = (state == S_FETCH);
    ctrl_start = (state == S_ISSUE);
  end

  // Program context, counters and registered status outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      base_q        <= '0;
      count_q       <= '0;
      idx           <= '0;
      rd_cnt        <= '0;
      tmo_cnt       <= '0;
      abort_pending <= 1'b0;
      done          <= 1'b0;
      err_timeout   <= 1'b0;
      insts_done    <= '0;
      imem_addr     <= '0;
      ctrl_inst     <= '0;
    end else begin
      done    <= (state == S_FINISH);
      rd_cnt  <= (state == S_WAIT_RD) ? rd_cnt + 2'd1 : 2'd0;
      tmo_cnt <= (state == S_WAIT_VALID) ? tmo_cnt + TW'(1) : '0;

      if (state == S_IDLE)  abort_pending <= 1'b0;
      else if (cmd_abort)   abort_pending <= 1'b1;

      case (state)
        S_IDLE: if (cmd_start) begin
          base_q      <= cmd_base;
          count_q     <= cmd_count;
          idx         <= '0;
          insts_done  <= '0;
          err_timeout <= 1'b0;
          if (cmd_count != 10'd0) imem_addr <= cmd_base;
        end
        S_WAIT_RD: if (rd_last && !abort_any && imem_dout != HALT) ctrl_inst <= imem_dout;
        S_WAIT_VALID: begin
          if (ctrl_valid) begin
            insts_done <= insts_done + 10'd1;
            idx        <= idx + 10'd1;
            // address of the next fetch, wrapping within the 10-bit space
            imem_addr  <= base_q + idx + 10'd1;
          end else if (tmo_hit) begin
            err_timeout <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_sequencer.sv
// Bench for inst_sequencer: memory and controller models, a negedge monitor that
// logs fetches/issues, and a program-level reference model for expected results.
module tb_inst_sequencer;
  localparam int LAT = 1;
  localparam logic [31:0] HALT = 32'h7FFF_FFFF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_start, cmd_abort, ctrl_valid;
  logic [9:0]  cmd_base, cmd_count;
  logic        busy, done, err_timeout, imem_en, ctrl_start;
  logic [9:0]  insts_done, imem_addr;
  logic [31:0] imem_dout, ctrl_inst;

  inst_sequencer #(.IMEM_LATENCY(LAT), .TIMEOUT(64)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_start(cmd_start), .cmd_base(cmd_base),
    .cmd_count(cmd_count), .cmd_abort(cmd_abort), .busy(busy), .done(done),
    .err_timeout(err_timeout), .insts_done(insts_done), .imem_en(imem_en),
    .imem_addr(imem_addr), .imem_dout(imem_dout), .ctrl_start(ctrl_start),
    .ctrl_inst(ctrl_inst), .ctrl_valid(ctrl_valid)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Instruction memory; reads outside a fetch return garbage to expose mistimed capture
  logic [31:0] mem [1024];
  logic [31:0] rd1, rd2;
  always @(posedge clk) begin
    rd1 <= imem_en ? mem[imem_addr] : 32'hDEAD_BEEF;
    rd2 <= rd1;
  end
  assign imem_dout = (LAT == 1) ? rd1 : rd2;

  // Controller model, abort injector and monitor
  logic [9:0]  addr_q [$];
  logic [31:0] inst_q [$];
  int  cyc = 0, vcnt = 0, n_starts = 0, done_cnt = 0;
  int  last_valid = -1, last_start_cyc = 0, err_rise_cyc = 0;
  int  abort_at = 0, ovr_lat = 0;
  bit  dead = 0, abort_dly = 0, prev_start = 0, err_prev = 0;

  always @(negedge clk) begin
    cyc++;
    ctrl_valid = 1'b0;
    cmd_abort  = abort_dly;
    abort_dly  = 1'b0;
    if (!rst_n) begin
      vcnt = 0; last_valid = -1; cmd_abort = 1'b0;
    end else begin
      if (vcnt > 0) begin
        vcnt--;
        if (vcnt == 0) begin ctrl_valid = 1'b1; last_valid = cyc; end
      end
      if (imem_en) addr_q.push_back(imem_addr);
      if (done) begin done_cnt++; last_valid = -1; end
      if (err_timeout && !err_prev) err_rise_cyc = cyc;
      if (ctrl_start) begin
        chk("start_back_to_back", 32'(prev_start), 32'd0);
        if (last_valid >= 0) chk("issue_overhead", cyc - last_valid, 2 + LAT);
        inst_q.push_back(ctrl_inst);
        n_starts++;
        last_start_cyc = cyc;
        if (n_starts == abort_at) abort_dly = 1'b1;
        if (!dead) vcnt = (ovr_lat != 0) ? ovr_lat : (ctrl_inst[31] ? 6 : 1);
      end
    end
    prev_start = ctrl_start;
    err_prev   = err_timeout;
  end

  // Reference: walk the program by address, stop at HALT, count or abort
  logic [9:0]  exp_addr [$];
  logic [31:0] exp_inst [$];
  task automatic model(input logic [9:0] b, input int c, input int ab);
    logic [9:0] a;
    exp_addr.delete(); exp_inst.delete();
    for (int i = 0; i < c; i++) begin
      a = 10'((int'(b) + i) % 1024);
      exp_addr.push_back(a);
      if (mem[a] == HALT) break;
      exp_inst.push_back(mem[a]);
      if (ab != 0 && exp_inst.size() == ab) break;
    end
  endtask

  task automatic clear_logs();
    addr_q.delete(); inst_q.delete();
    n_starts = 0; done_cnt = 0;
  endtask

  task automatic start_prog(input logic [9:0] b, input logic [9:0] c);
    clear_logs();
    @(negedge clk);
    cmd_base = b; cmd_count = c; cmd_start = 1'b1;
    @(negedge clk);
    cmd_start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    bit seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    if (!seen) chk("done_wait_expired", 32'd0, 32'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic compare(input string tag, input int exp_done, input bit exp_err);
    chk({tag, "_n_fetch"}, addr_q.size(), exp_addr.size());
    for (int i = 0; i < exp_addr.size() && i < addr_q.size(); i++)
      chk({tag, "_fetch_addr"}, 32'(addr_q[i]), 32'(exp_addr[i]));
    chk({tag, "_n_issue"}, inst_q.size(), exp_inst.size());
    for (int i = 0; i < exp_inst.size() && i < inst_q.size(); i++)
      chk({tag, "_inst"}, inst_q[i], exp_inst[i]);
    chk({tag, "_insts_done"}, 32'(insts_done), exp_done);
    chk({tag, "_err_timeout"}, 32'(err_timeout), 32'(exp_err));
    chk({tag, "_done_pulses"}, done_cnt, 1);
    chk({tag, "_busy_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic run_case(input string tag, input logic [9:0] b, input logic [9:0] c, input int ab);
    abort_at = ab;
    model(b, int'(c), ab);
    start_prog(b, c);
    wait_done(2000);
    compare(tag, exp_inst.size(), 1'b0);
    abort_at = 0;
  endtask

  initial begin
    logic [9:0]  rb, rc;
    logic [31:0] r;
    int          ab;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h8000_0000 | i;
    rst_n = 1'b0; cmd_start = 1'b0; cmd_base = '0; cmd_count = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err_timeout), 0);
    chk("rst_imem_en", 32'(imem_en), 0);
    chk("rst_ctrl_start", 32'(ctrl_start), 0);
    chk("rst_addr", 32'(imem_addr), 0);
    chk("rst_inst", ctrl_inst, 0);
    chk("rst_insts_done", 32'(insts_done), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // basic two-instruction program
    mem[10'h010] = 32'h8000_0421; mem[10'h011] = 32'h8000_0842;
    run_case("basic", 10'h010, 10'd2, 0);

    // address wrap at the top of memory
    run_case("wrap", 10'h3FE, 10'd3, 0);

    // empty program: done two cycles after the sampled start, no traffic
    start_prog(10'h100, 10'd0);
    chk("cnt0_busy", 32'(busy), 1);
    chk("cnt0_done_early", 32'(done), 0);
    @(negedge clk);
    chk("cnt0_done", 32'(done), 1);
    chk("cnt0_busy_after", 32'(busy), 0);
    repeat (2) @(negedge clk);
    chk("cnt0_fetches", addr_q.size(), 0);
    chk("cnt0_issues", inst_q.size(), 0);

    // controller never answers: timeout after 64 waiting cycles
    dead = 1;
    start_prog(10'h020, 10'd2);
    wait_done(300);
    chk("tmo_err", 32'(err_timeout), 1);
    chk("tmo_issues", inst_q.size(), 1);
    chk("tmo_insts_done", 32'(insts_done), 0);
    chk("tmo_latency", err_rise_cyc - last_start_cyc, 65);
    dead = 0;
    start_prog(10'h020, 10'd0);
    chk("tmo_clear", 32'(err_timeout), 0);
    wait_done(20);

    // valid arriving in the last allowed cycle beats the timeout
    ovr_lat = 64;
    run_case("valid_at_limit", 10'h030, 10'd1, 0);
    ovr_lat = 0;

    // HALT in the third slot
    mem[10'h042] = HALT;
    run_case("halt", 10'h040, 10'd5, 0);

    // abort during the second wait
    run_case("abort", 10'h050, 10'd4, 2);

    // reset in the middle of a program
    start_prog(10'h060, 10'd5);
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_insts_done", 32'(insts_done), 0);
    chk("mid_rst_addr", 32'(imem_addr), 0);
    chk("mid_rst_inst", ctrl_inst, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // randomized programs, some with HALT and some aborted
    for (int t = 0; t < 20; t++) begin
      rb = 10'($urandom_range(0, 1023));
      rc = 10'($urandom_range(1, 10));
      for (int i = 0; i < int'(rc); i++) begin
        r = $urandom;
        if (r == HALT) r = r ^ 32'h1;
        if ($urandom_range(0, 7) == 0) r = HALT;
        mem[(int'(rb) + i) % 1024] = r;
      end
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, int'(rc))) : 0;
      run_case("rand", rb, rc, ab);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
